// File: rtl/clk_div_ctrl.sv
// Run/stop and reconfiguration controller for a toggle-type clock divider.
// New half-period values take effect only at a toggle boundary, so fout never produces a runt pulse.
module clk_div_ctrl #(
  parameter int          CNT_W    = 18,
  parameter int unsigned DEF_HALF = 249_999,
  parameter int unsigned MIN_HALF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             fout,
  output logic             tick,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a config transfers on any rising clk edge where cfg_valid and cfg_ready are both 1.
  // The source holds cfg_half stable while cfg_valid is high. cfg_ready is low only while a value is pending.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic [CNT_W-1:0] half, half_d;
  logic [CNT_W-1:0] pend, pend_d;
  logic             fout_d, tick_d, err_d;
  logic             accept, legal, toggle;

  assign accept    = cfg_valid & cfg_ready;
  assign legal     = (cfg_half >= CNT_W'(MIN_HALF));
  assign toggle    = (count == half);
  assign dbg_state = state;

  always_comb begin
    state_d = state;
    count_d = count;
    half_d  = half;
    pend_d  = pend;
    fout_d  = fout;
    tick_d  = 1'b0;
    err_d   = accept & ~legal;
    case (state)
      IDLE: begin
        if (accept && legal) half_d = cfg_half;
        if (run) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      RUN: begin
        if (!run) begin
          // Stop wins over a simultaneous config, which is applied directly.
          state_d = IDLE;
          fout_d  = 1'b0;
          count_d = '0;
          if (accept && legal) half_d = cfg_half;
        end else begin
          if (toggle) begin
            count_d = '0;
            fout_d  = ~fout;
            tick_d  = ~fout;
          end else begin
            count_d = count + CNT_W'(1);
          end
          // A value accepted on a toggle edge waits for the following toggle.
          if (accept && legal) begin
            pend_d  = cfg_half;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (!run) begin
          state_d = IDLE;
          fout_d  = 1'b0;
          count_d = '0;
          half_d  = pend;
        end else if (toggle) begin
          state_d = RUN;
          count_d = '0;
          fout_d  = ~fout;
          tick_d  = ~fout;
          half_d  = pend;
        end else begin
          count_d = count + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        fout_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      half      <= CNT_W'(DEF_HALF);
      pend      <= '0;
      fout      <= 1'b0;
      tick      <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      half      <= half_d;
      pend      <= pend_d;
      fout      <= fout_d;
      tick      <= tick_d;
      cfg_err   <= err_d;
      cfg_ready <= (state_d != PEND);
      busy      <= (state_d != IDLE);
    end
  end

endmodule
